alu_mdu: RTL and testbench

//  Parametrised execute-stage ALU with an attached iterative multiply/divide unit (MDU).

---
 rtl/alu_mdu.sv | 171 +++++++++++++++++
 tb/tb_alu_mdu.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// Execute-stage ALU with an iterative multiply/divide unit that writes HI/LO.
// Build option: define ALU_MDU_DIV_EN to include the restoring divider.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       af,
    input  logic             i,
    output logic [WIDTH-1:0] alures,
    output logic             ovfalu,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             md_err
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

    // ---------------- single-cycle ALU ----------------
    logic [WIDTH-1:0] addsub;
    logic             add_ovf;

    always_comb begin
        addsub  = af[1] ? a - b : a + b;
        add_ovf = (af[1] ? (a[WIDTH-1] != b[WIDTH-1]) : (a[WIDTH-1] == b[WIDTH-1]))
                  && (addsub[WIDTH-1] != a[WIDTH-1]);
        case (af)
            4'b0000, 4'b0001,
            4'b0010, 4'b0011: alures = addsub;
            4'b0100:          alures = a & b;
            4'b0101:          alures = a | b;
            4'b0110:          alures = a ^ b;
            4'b0111:          alures = i ? {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}} : ~(a | b);
            4'b1010:          alures = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            4'b1011:          alures = {{(WIDTH-1){1'b0}}, a < b};
            default:          alures = '0;
        endcase
        ovfalu = add_ovf & ~af[0] & ~af[3] & ~af[2];
    end

    // ---------------- MDU datapath ----------------
    state_t             state;
    logic [CNTW-1:0]    cnt;
    logic [2*WIDTH-1:0] prod;      // mult: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
    logic               is_div;
    logic               neg_q;

    logic               sgn;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, mul_res;

    always_comb begin
        sgn      = ~md_op[0];
        mag_a    = (sgn && a[WIDTH-1]) ? -a : a;
        mag_b    = (sgn && b[WIDTH-1]) ? -b : b;
        mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, prod[WIDTH-1:1]};
        mul_res  = neg_q ? -prod : prod;
    end

`ifdef ALU_MDU_DIV_EN
    logic               neg_r;
    logic               dz;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff, div_hi, div_lo;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd};
        // Once the trial fits, the true difference is below 2**WIDTH, so modular subtraction is exact.
        div_diff  = div_shift[WIDTH-1:0] - opnd;
        div_next  = div_ge ? {div_diff, prod[WIDTH-2:0], 1'b1}
                           : {div_shift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
        div_hi    = neg_r ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
        div_lo    = dz ? '1 : (neg_q ? -prod[WIDTH-1:0] : prod[WIDTH-1:0]);
    end
`endif

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            prod   <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            md_err <= 1'b0;
`ifdef ALU_MDU_DIV_EN
            neg_r  <= 1'b0;
            dz     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (mthi) hi <= a;
                    if (mtlo) lo <= a;
                    if (md_start) begin
                        state  <= CALC;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        md_err <= 1'b0;
                        is_div <= md_op[1];
                        neg_q  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ALU_MDU_DIV_EN
                        neg_r  <= sgn & a[WIDTH-1];
                        dz     <= (b == '0);
`endif
                        if (md_op[1]) begin
                            prod <= {{WIDTH{1'b0}}, mag_a};
                            opnd <= mag_b;
                        end else begin
                            prod <= {{WIDTH{1'b0}}, mag_b};
                            opnd <= mag_a;
                        end
                    end
                end
                CALC: begin
`ifdef ALU_MDU_DIV_EN
                    prod <= is_div ? div_next : mul_next;
`else
                    if (!is_div) prod <= mul_next;
`endif
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= FIX;
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    if (is_div) begin
`ifdef ALU_MDU_DIV_EN
                        hi     <= div_hi;
                        lo     <= div_lo;
                        md_err <= dz;
`else
                        hi     <= '0;
                        lo     <= '0;
                        md_err <= 1'b1;
`endif
                    end else begin
                        {hi, lo} <= mul_res;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu at WIDTH=32; divide expectations follow ALU_MDU_DIV_EN.
module tb_alu_mdu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] a, b;
    logic [3:0]   af;
    logic         i;
    logic [W-1:0] alures;
    logic         ovfalu;
    logic         md_start;
    logic [1:0]   md_op;
    logic         mthi, mtlo;
    logic         busy, done;
    logic [W-1:0] hi, lo;
    logic         md_err;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    alu_mdu #(.WIDTH(W), .CNTW(6)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .af(af), .i(i),
        .alures(alures), .ovfalu(ovfalu),
        .md_start(md_start), .md_op(md_op), .mthi(mthi), .mtlo(mtlo),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .md_err(md_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an MDU op for exactly one edge; returns just after the sampling edge.
    task automatic start_md(input logic [1:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb,
                            input logic lo_move);
        a = aa; b = bb; md_op = op; md_start = 1'b1; mtlo = lo_move;
        step();
        md_start = 1'b0; mtlo = 1'b0;
    endtask

    // Counts edges until done is seen; a bound keeps the run finite.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            step();
            n++;
        end
        if (!done) check("done_timeout", 64'(n), 64'd0);
    endtask

    task automatic alu(input string tag, input logic [3:0] f, input logic ii,
                       input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic [W-1:0] exp_res, input logic exp_ovf);
        af = f; i = ii; a = aa; b = bb;
        #1;
        check({tag, "_res"}, 64'(alures), 64'(exp_res));
        check({tag, "_ovf"}, 64'(ovfalu), 64'(exp_ovf));
    endtask

    int n, pulses;
    logic [W-1:0] e_hi, e_lo;
    logic         e_err;

    initial begin
        reset = 1'b1; a = '0; b = '0; af = '0; i = 1'b0;
        md_start = 1'b0; md_op = '0; mthi = 1'b0; mtlo = 1'b0;
        step(); step();
        reset = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_err", 64'(md_err), 64'd0);

        // ALU vectors
        alu("add_ovf",  4'b0000, 1'b0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b1);
        alu("addu",     4'b0001, 1'b0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0);
        alu("sub",      4'b0010, 1'b0, 32'h5,        32'h7,        32'hFFFFFFFE, 1'b0);
        alu("sub_ovf",  4'b0010, 1'b0, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b1);
        alu("subu",     4'b0011, 1'b0, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b0);
        alu("and",      4'b0100, 1'b0, 32'hF0F0FFFF, 32'h0FF0F00F, 32'h00F0F00F, 1'b0);
        alu("or",       4'b0101, 1'b0, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0);
        alu("xor",      4'b0110, 1'b0, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 1'b0);
        alu("nor",      4'b0111, 1'b0, 32'hF0000000, 32'h0000000F, 32'h0FFFFFF0, 1'b0);
        alu("lui",      4'b0111, 1'b1, 32'hFFFFFFFF, 32'hABCD1234, 32'h12340000, 1'b0);
        alu("slt",      4'b1010, 1'b0, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0);
        alu("sltu",     4'b1011, 1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0);
        alu("unused",   4'b1100, 1'b0, 32'h12345678, 32'h1,        32'h0,        1'b0);

        // MULT -2*3 with exact latency
        step();
        start_md(MULT, 32'hFFFFFFFE, 32'h3, 1'b0);
        check("mult_busy", 64'(busy), 64'd1);
        wait_done(n);
        check("mult_lat", 64'(n + 1), 64'd34);
        check("mult_busy_at_done", 64'(busy), 64'd0);
        check("mult_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
        step();
        check("done_pulse", 64'(done), 64'd0);

        start_md(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        wait_done(n);
        check("multu_res", {hi, lo}, 64'hFFFFFFFE_00000001);

`ifdef ALU_MDU_DIV_EN
        e_hi = 32'hFFFFFFFF; e_lo = 32'hFFFFFFFD; e_err = 1'b0;
`else
        e_hi = '0; e_lo = '0; e_err = 1'b1;
`endif
        start_md(DIV, 32'hFFFFFFF9, 32'h2, 1'b0);
        wait_done(n);
        check("div_lat", 64'(n + 1), 64'd34);
        check("div_res", {hi, lo}, {e_hi, e_lo});
        check("div_err", 64'(md_err), 64'(e_err));

`ifdef ALU_MDU_DIV_EN
        e_hi = 32'h7; e_lo = 32'hFFFFFFFF;
`else
        e_hi = '0; e_lo = '0;
`endif
        start_md(DIVU, 32'h7, 32'h0, 1'b0);
        wait_done(n);
        check("divz_lat", 64'(n + 1), 64'd34);
        check("divz_res", {hi, lo}, {e_hi, e_lo});
        check("divz_err", 64'(md_err), 64'd1);

        // md_err clears on the next accepted start
        start_md(MULTU, 32'h2, 32'h2, 1'b0);
        check("err_clear", 64'(md_err), 64'd0);
        wait_done(n);
        check("mul4", {hi, lo}, 64'd4);

`ifdef ALU_MDU_DIV_EN
        e_hi = '0; e_lo = 32'h80000000; e_err = 1'b0;
`else
        e_hi = '0; e_lo = '0; e_err = 1'b1;
`endif
        start_md(DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        wait_done(n);
        check("divmin_res", {hi, lo}, {e_hi, e_lo});
        check("divmin_err", 64'(md_err), 64'(e_err));

`ifdef ALU_MDU_DIV_EN
        e_hi = '0; e_lo = 32'h4; e_err = 1'b0;
`else
        e_hi = '0; e_lo = '0; e_err = 1'b1;
`endif
        start_md(DIV, 32'h8, 32'h2, 1'b0);
        wait_done(n);
        check("div8_lat", 64'(n + 1), 64'd34);
        check("div8_res", {hi, lo}, {e_hi, e_lo});
        check("div8_err", 64'(md_err), 64'(e_err));

        // Moves while idle
        step();
        a = 32'h12345678; mthi = 1'b1; step(); mthi = 1'b0;
        a = 32'h9ABCDEF0; mtlo = 1'b1; step(); mtlo = 1'b0;
        check("mthi_mtlo", {hi, lo}, 64'h12345678_9ABCDEF0);

        // Start and move ignored while busy
        start_md(MULTU, 32'h5, 32'h6, 1'b0);
        repeat (4) step();
        a = 32'hDEADBEEF; b = '0; md_op = DIV; md_start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
        step();
        md_start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        check("busy_move_ign", {hi, lo}, 64'h12345678_9ABCDEF0);
        wait_done(n);
        check("busy_start_lat", 64'(n + 6), 64'd34);
        check("busy_start_res", {hi, lo}, 64'h00000000_0000001E);

        // Move together with an accepted start, then back-to-back start on done
        start_md(MULTU, 32'h55, 32'h2, 1'b1);
        check("move_with_start", 64'(lo), 64'h55);
        wait_done(n);
        check("move_overwritten", {hi, lo}, 64'hAA);
        start_md(MULT, 32'h3, 32'hFFFFFFFC, 1'b0);
        check("b2b_busy", 64'(busy), 64'd1);
        wait_done(n);
        check("b2b_lat", 64'(n + 1), 64'd34);
        check("b2b_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFF4);

        // Reset mid-op aborts without writing
        step();
        start_md(MULT, 32'h3, 32'h4, 1'b0);
        repeat (9) step();
        reset = 1'b1; step(); reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (done) pulses++;
        end
        check("abort_no_done", 64'(pulses), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
